// File: rtl/delta_state_enc.sv
`default_nettype none
// ============================================================================
// delta_state_enc : saturating, thresholded delta encoder in front of the
//                   previous-state bank, with read-after-write forwarding.
// Revision 1.0
// ============================================================================
module delta_state_enc #(
    parameter int NUM_PE             = 16,
    parameter int ACT_INT_BW         = 8,
    parameter int ACT_FRA_BW         = 8,
    parameter int NUM_LAYER_BW       = 2,
    parameter int MEM_STATE_DEPTH_BW = 5,
    localparam int ACT_BW  = ACT_INT_BW + ACT_FRA_BW,
    localparam int ADDR_W  = MEM_STATE_DEPTH_BW + 1,
    localparam int PC_W    = $clog2(NUM_PE + 1),
    localparam int CNT_W   = ADDR_W + PC_W,
    localparam int DATA_W  = NUM_PE * ACT_BW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ACT_BW-1:0]       cfg_thx,
    input  logic [NUM_LAYER_BW-1:0] cfg_layer,
    input  logic                    cfg_init,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ADDR_W-1:0]       s_addr,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_last,
    output logic                    prev_rd_en,
    output logic [NUM_LAYER_BW-1:0] prev_l_rd_addr,
    output logic [ADDR_W-1:0]       prev_rd_addr,
    input  logic [DATA_W-1:0]       prev_dout,
    output logic [NUM_PE-1:0]       prev_wr_en,
    output logic [NUM_LAYER_BW-1:0] prev_l_wr_addr,
    output logic [ADDR_W-1:0]       prev_wr_addr,
    output logic [DATA_W-1:0]       prev_din,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_W-1:0]       m_addr,
    output logic [DATA_W-1:0]       m_delta,
    output logic [NUM_PE-1:0]       m_nz,
    output logic                    m_last,
    output logic [CNT_W-1:0]        frame_nz_cnt,
    output logic                    frame_done
);

    localparam logic [ACT_BW-1:0] SAT_MIN = {1'b1, {(ACT_BW-1){1'b0}}};
    localparam logic [ACT_BW-1:0] SAT_MAX = {1'b0, {(ACT_BW-1){1'b1}}};
    localparam logic [ACT_BW-1:0] ONE     = {{(ACT_BW-1){1'b0}}, 1'b1};

    logic                en;
    logic                accept;
    logic                xfer;

    logic                st1_valid_q;
    logic [ADDR_W-1:0]   st1_addr_q;
    logic [DATA_W-1:0]   st1_data_q;
    logic                st1_last_q;

    logic [NUM_PE-1:0]   fwd_mask_q;
    logic [DATA_W-1:0]   fwd_data_q;

    logic                m_valid_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_delta_q;
    logic [NUM_PE-1:0]   m_nz_q;
    logic                m_last_q;

    logic [CNT_W-1:0]    acc_q;
    logic [CNT_W-1:0]    acc_d;
    logic [CNT_W-1:0]    frame_cnt_q;
    logic                frame_done_q;

    logic [NUM_PE-1:0]   w_nz;
    logic [DATA_W-1:0]   w_delta;
    logic [PC_W-1:0]     w_pc;

    assign en     = !m_valid_q | m_ready;
    assign accept = s_valid & en;
    assign xfer   = st1_valid_q & en;

    assign s_ready        = en;
    assign prev_rd_en     = accept;
    assign prev_rd_addr   = s_addr;
    assign prev_l_rd_addr = cfg_layer;

    // Write-back mirrors the transfer; rst gates it so nothing lands after reset asserts.
    assign prev_wr_en     = (xfer && !rst) ? w_nz : '0;
    assign prev_wr_addr   = st1_addr_q;
    assign prev_l_wr_addr = cfg_layer;
    assign prev_din       = st1_data_q;

    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        logic [ACT_BW-1:0] w_cur;
        logic [ACT_BW-1:0] w_prev;
        logic [ACT_BW:0]   w_diff;
        logic [ACT_BW-1:0] w_sat;
        logic [ACT_BW-1:0] w_abs;

        assign w_cur  = st1_data_q[i*ACT_BW +: ACT_BW];
        assign w_prev = fwd_mask_q[i] ? fwd_data_q[i*ACT_BW +: ACT_BW]
                                      : prev_dout[i*ACT_BW +: ACT_BW];
        assign w_diff = {w_cur[ACT_BW-1], w_cur} - {w_prev[ACT_BW-1], w_prev};
        assign w_sat  = (w_diff[ACT_BW] != w_diff[ACT_BW-1])
                      ? (w_diff[ACT_BW] ? SAT_MIN : SAT_MAX)
                      : w_diff[ACT_BW-1:0];
        // The most negative value maps to itself, which is correct as unsigned.
        assign w_abs  = w_sat[ACT_BW-1] ? ((~w_sat) + ONE) : w_sat;
        assign w_nz[i] = cfg_init | (w_abs > cfg_thx);
        assign w_delta[i*ACT_BW +: ACT_BW] = w_nz[i] ? w_sat : '0;
    end

    always_comb begin
        w_pc = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_pc = w_pc + PC_W'(w_nz[i]);
        end
    end

    assign acc_d = acc_q + CNT_W'(w_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st1_valid_q  <= 1'b0;
            st1_addr_q   <= '0;
            st1_data_q   <= '0;
            st1_last_q   <= 1'b0;
            fwd_mask_q   <= '0;
            fwd_data_q   <= '0;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_delta_q    <= '0;
            m_nz_q       <= '0;
            m_last_q     <= 1'b0;
            acc_q        <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (en) begin
                st1_valid_q <= s_valid;
                if (s_valid) begin
                    st1_addr_q <= s_addr;
                    st1_data_q <= s_data;
                    st1_last_q <= s_last;
                end
                // The bank read issued this cycle misses the write landing in the same edge.
                fwd_mask_q <= (accept && xfer && (s_addr == st1_addr_q)) ? w_nz : '0;
                if (xfer) begin
                    fwd_data_q <= st1_data_q;
                end
            end

            if (xfer) begin
                m_valid_q <= 1'b1;
                m_addr_q  <= st1_addr_q;
                m_delta_q <= w_delta;
                m_nz_q    <= w_nz;
                m_last_q  <= st1_last_q;
                if (st1_last_q) begin
                    frame_cnt_q  <= acc_d;
                    frame_done_q <= 1'b1;
                    acc_q        <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid      = m_valid_q;
    assign m_addr       = m_addr_q;
    assign m_delta      = m_delta_q;
    assign m_nz         = m_nz_q;
    assign m_last       = m_last_q;
    assign frame_nz_cnt = frame_cnt_q;
    assign frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_delta_state_enc.sv
`default_nettype none
// Scoreboarded directed bench for delta_state_enc with a behavioural state bank.
module tb_delta_state_enc;

    localparam int NPE = 16;
    localparam int AW  = 6;
    localparam int DW  = 256;
    localparam int CW  = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   cfg_thx;
    logic [1:0]    cfg_layer;
    logic          cfg_init;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          prev_rd_en;
    logic [1:0]    prev_l_rd_addr;
    logic [AW-1:0] prev_rd_addr;
    logic [DW-1:0] prev_dout;
    logic [NPE-1:0] prev_wr_en;
    logic [1:0]    prev_l_wr_addr;
    logic [AW-1:0] prev_wr_addr;
    logic [DW-1:0] prev_din;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_delta;
    logic [NPE-1:0] m_nz;
    logic          m_last;
    logic [CW-1:0] frame_nz_cnt;
    logic          frame_done;

    delta_state_enc dut (
        .clk(clk), .rst(rst),
        .cfg_thx(cfg_thx), .cfg_layer(cfg_layer), .cfg_init(cfg_init),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
        .prev_rd_en(prev_rd_en), .prev_l_rd_addr(prev_l_rd_addr), .prev_rd_addr(prev_rd_addr),
        .prev_dout(prev_dout),
        .prev_wr_en(prev_wr_en), .prev_l_wr_addr(prev_l_wr_addr), .prev_wr_addr(prev_wr_addr),
        .prev_din(prev_din),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_delta(m_delta),
        .m_nz(m_nz), .m_last(m_last),
        .frame_nz_cnt(frame_nz_cnt), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural previous-state bank: registered read, held while rd_en is low.
    logic [DW-1:0] mem [256];
    logic          poke_en = 1'b0;
    logic [1:0]    poke_layer;
    logic [AW-1:0] poke_addr;
    logic [DW-1:0] poke_val;

    always @(posedge clk) begin
        if (prev_rd_en) prev_dout <= mem[{prev_l_rd_addr, prev_rd_addr}];
        for (int i = 0; i < NPE; i++)
            if (prev_wr_en[i]) mem[{prev_l_wr_addr, prev_wr_addr}][i*16 +: 16] <= prev_din[i*16 +: 16];
        if (poke_en) mem[{poke_layer, poke_addr}] <= poke_val;
    end

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] delta; logic [NPE-1:0] nz; logic last; } out_t;
    typedef struct { logic [1:0] layer; logic [AW-1:0] addr; logic [NPE-1:0] en; logic [DW-1:0] din; } wr_t;

    out_t          out_q[$];
    wr_t           wr_q[$];
    logic [CW-1:0] frm_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [15:0] x);
        logic [DW-1:0] v;
        for (int i = 0; i < NPE; i++) v[i*16 +: 16] = x;
        return v;
    endfunction

    function automatic logic [DW-1:0] setl(input logic [DW-1:0] v, input int i, input logic [15:0] x);
        v[i*16 +: 16] = x;
        return v;
    endfunction

    // Monitor: handshakes seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (out_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out: got beat addr %h nz %h, expected none", m_addr, m_nz);
                end else begin
                    out_t e;
                    e = out_q.pop_front();
                    chk("m_addr", DW'(m_addr), DW'(e.addr));
                    chk("m_nz", DW'(m_nz), DW'(e.nz));
                    chk("m_delta", m_delta, e.delta);
                    chk("m_last", DW'(m_last), DW'(e.last));
                end
            end
            if (prev_wr_en != '0) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wr: got en %h addr %h, expected none", prev_wr_en, prev_wr_addr);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_en", DW'(prev_wr_en), DW'(w.en));
                    chk("wr_addr", DW'({prev_l_wr_addr, prev_wr_addr}), DW'({w.layer, w.addr}));
                    chk("wr_din", prev_din, w.din);
                end
            end
            if (frame_done) begin
                if (frm_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: got %0d, expected none", frame_nz_cnt);
                end else begin
                    chk("frame_nz_cnt", DW'(frame_nz_cnt), DW'(frm_q.pop_front()));
                end
            end
        end
    end

    task automatic poke(input logic [1:0] l, input logic [AW-1:0] a, input logic [DW-1:0] v);
        poke_layer = l; poke_addr = a; poke_val = v; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last,
                        input logic [DW-1:0] e_delta, input logic [NPE-1:0] e_nz,
                        input bit p_out, input bit p_wr);
        out_t o;
        wr_t  w;
        int   n;
        if (p_out) begin
            o.addr = a; o.delta = e_delta; o.nz = e_nz; o.last = last;
            out_q.push_back(o);
        end
        if (p_wr && e_nz != '0) begin
            w.layer = cfg_layer; w.addr = a; w.en = e_nz; w.din = d;
            wr_q.push_back(w);
        end
        s_valid = 1'b1; s_addr = a; s_data = d; s_last = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: got s_ready 0 for %0d cycles, expected 1", n);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((out_q.size() != 0 || wr_q.size() != 0 || frm_q.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_out_q", DW'(out_q.size()), '0);
        chk("drain_wr_q", DW'(wr_q.size()), '0);
        chk("drain_frm_q", DW'(frm_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d, e, a_data, b_data;

        rst = 1'b1; s_valid = 1'b0; s_addr = '0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b1; cfg_thx = '0; cfg_layer = '0; cfg_init = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_m_valid", DW'(m_valid), '0);
        chk("rst_wr_en", DW'(prev_wr_en), '0);
        chk("rst_frame_cnt", DW'(frame_nz_cnt), '0);
        chk("rst_frame_done", DW'(frame_done), '0);
        chk("rst_rd_en", DW'(prev_rd_en), '0);
        rst = 1'b0; #1;
        chk("rst_s_ready", DW'(s_ready), 1);
        @(posedge clk); #1;

        for (int a = 0; a < 4; a++) poke(2'd0, AW'(a), '0);
        poke(2'd0, 6'd5, '0);
        poke(2'd0, 6'd10, setl(rep(16'h7F00), 1, 16'h8000));
        for (int a = 20; a < 23; a++) poke(2'd2, AW'(a), '0);
        poke(2'd0, 6'd24, '0);
        poke(2'd0, 6'd25, '0);
        poke(2'd0, 6'd30, '0);

        // Init timestep: every lane fires regardless of threshold.
        cfg_init = 1'b1;
        frm_q.push_back(11'd64);
        for (int a = 0; a < 4; a++)
            send(AW'(a), rep(16'h0100), a == 3, rep(16'h0100), 16'hFFFF, 1, 1);
        drain();

        // Threshold: only lane 1 exceeds 0x0080.
        cfg_init = 1'b0; cfg_thx = 16'h0080;
        d = setl(setl(setl(rep(16'h0100), 0, 16'h0150), 1, 16'h0190), 2, 16'h00A0);
        frm_q.push_back(11'd1);
        send(6'd0, d, 1'b1, setl('0, 1, 16'h0090), 16'h0002, 1, 1);
        drain();

        // Saturation in both directions.
        d = setl(setl(rep(16'h7F00), 0, 16'h8000), 1, 16'h7F00);
        e = setl(setl('0, 0, 16'h8000), 1, 16'h7FFF);
        frm_q.push_back(11'd2);
        send(6'd10, d, 1'b1, e, 16'h0003, 1, 1);
        drain();

        // Maximum threshold without init: nothing fires.
        cfg_thx = 16'hFFFF;
        frm_q.push_back(11'd0);
        send(6'd10, '0, 1'b1, '0, 16'h0000, 1, 1);
        drain();

        // Back-to-back to the same address exercises forwarding.
        cfg_thx = 16'h0080;
        a_data = setl(setl('0, 0, 16'h0200), 3, 16'h0300);
        b_data = setl(setl(a_data, 1, 16'h0050), 3, 16'h0400);
        frm_q.push_back(11'd3);
        send(6'd5, a_data, 1'b0, a_data, 16'h0009, 1, 1);
        send(6'd5, b_data, 1'b1, setl('0, 3, 16'h0100), 16'h0008, 1, 1);
        drain();

        // Downstream stall with three beats offered on layer 2.
        cfg_layer = 2'd2;
        m_ready = 1'b0;
        frm_q.push_back(11'd3);
        fork
            begin
                for (int k = 1; k <= 3; k++)
                    send(AW'(19 + k), setl('0, 0, 16'(k * 256)), k == 3,
                         setl('0, 0, 16'(k * 256)), 16'h0001, 1, 1);
            end
            begin
                repeat (4) @(posedge clk); #1;
                chk("stall_s_ready", DW'(s_ready), '0);
                chk("stall_wr_en", DW'(prev_wr_en), '0);
                chk("stall_m_valid", DW'(m_valid), 1);
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight; only the first beat's write-back precedes it.
        cfg_layer = 2'd0;
        m_ready = 1'b0;
        send(6'd24, rep(16'h0400), 1'b0, '0, 16'hFFFF, 0, 1);
        send(6'd25, rep(16'h0400), 1'b0, '0, 16'hFFFF, 0, 0);
        m_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", DW'(m_valid), '0);
        chk("mid_rst_wr_en", DW'(prev_wr_en), '0);
        chk("mid_rst_frame_cnt", DW'(frame_nz_cnt), '0);
        chk("mid_rst_m_nz", DW'(m_nz), '0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("post_rst_s_ready", DW'(s_ready), 1);
        repeat (5) @(posedge clk); #1;

        // Init overrides maximum threshold; accumulator must restart from zero.
        cfg_init = 1'b1; cfg_thx = 16'hFFFF;
        frm_q.push_back(11'd16);
        send(6'd30, rep(16'h1234), 1'b1, rep(16'h1234), 16'hFFFF, 1, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
